// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Runs one input activation vector through NUM_LAYERS passes of a shared
// combinational mat_mul datapath, then picks the signed argmax of the final
// vector and presents the vector and its class on a valid/ready output.
//
// Each pass drives the current activation and layer index into mat_mul, opens
// the compute window by pulling mm_done low, waits SETTLE cycles plus the
// mat_mul result flag, and writes the result back as the next activation.
// The controller does no arithmetic; every value passes bit-exact.
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input vector valid
//   in_ready   controller accepts input (IDLE and not in reset)
//   in_vec     input activation vector, W words of N bits
//   mm_vec     activation driven to mat_mul (valid in RUN)
//   mm_layer   layer index to mat_mul and the weight/bias ROM (valid in RUN)
//   mm_done    0 = mat_mul compute window open; 1 re-arms mat_mul's flag
//   mm_flag    mat_mul result valid
//   mm_out     mat_mul result vector
//   out_valid  final result valid (DONE)
//   out_ready  downstream accepts the result
//   out_vec    final-layer activation vector
//   out_class  index of the largest signed element of out_vec (lowest on tie)
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int N          = 32,
  parameter int W          = 6,
  parameter int NUM_LAYERS = 4,
  parameter int SETTLE     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0][N-1:0]  in_vec,
  output logic [W-1:0][N-1:0]  mm_vec,
  output logic [1:0]           mm_layer,
  output logic                 mm_done,
  input  logic                 mm_flag,
  input  logic [W-1:0][N-1:0]  mm_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0][N-1:0]  out_vec,
  output logic [$clog2(W)-1:0] out_class,
  output logic                 busy
);

  localparam int CW = $clog2(W);
  // A SETTLE of 1 still needs a one-bit counter that simply sits at zero.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [1:0]    LAYER_LAST  = 2'(NUM_LAYERS - 1);
  localparam logic [CW-1:0] SCAN_LAST   = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_NEXT,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Datapath registers
  logic [W-1:0][N-1:0] r_buf;        // current activation
  logic [1:0]          r_layer;
  logic [SW-1:0]       r_settle;
  logic [CW-1:0]       r_scan;       // argmax element under inspection
  logic [N-1:0]        r_max;        // running maximum (signed)
  logic [CW-1:0]       r_max_idx;
  logic [W-1:0][N-1:0] r_out_vec;
  logic [CW-1:0]       r_out_class;

  logic          w_accept;
  logic          w_settled;
  logic          w_last_layer;
  logic          w_scan_last;
  logic [N-1:0]  w_elem;
  logic          w_take;
  logic [CW-1:0] w_win_idx;

  assign w_accept     = in_valid && in_ready;
  assign w_settled    = (r_settle == SETTLE_LAST);
  assign w_last_layer = (r_layer == LAYER_LAST);
  assign w_scan_last  = (r_scan == SCAN_LAST);

  // Argmax step: element 0 seeds the maximum; afterwards only a strictly
  // greater signed value replaces it, so ties keep the lowest index.
  assign w_elem    = r_buf[r_scan];
  assign w_take    = (r_scan == '0) || ($signed(w_elem) > $signed(r_max));
  assign w_win_idx = w_take ? r_scan : r_max_idx;

  assign out_vec   = r_out_vec;
  assign out_class = r_out_class;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that left one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    mm_done     = 1'b1;
    mm_vec      = '0;
    mm_layer    = '0;
    out_valid   = 1'b0;
    busy        = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (in_valid && !rst) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        mm_done  = 1'b0;
        mm_vec   = r_buf;
        mm_layer = r_layer;
        // No timeout: a late flag simply stretches the window.
        if (w_settled && mm_flag) begin
          w_state_nxt = S_NEXT;
        end
      end

      // One cycle with mm_done high re-arms mat_mul's flag between passes.
      S_NEXT: begin
        w_state_nxt = w_last_layer ? S_ARGMAX : S_RUN;
      end

      S_ARGMAX: begin
        if (w_scan_last) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: the activation buffer is a handful of flops, not a RAM, so it is
  // reset along with everything else; an aborted vector leaves no trace.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf       <= '0;
      r_layer     <= '0;
      r_settle    <= '0;
      r_scan      <= '0;
      r_max       <= '0;
      r_max_idx   <= '0;
      r_out_vec   <= '0;
      r_out_class <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buf    <= in_vec;
            r_layer  <= '0;
            r_settle <= '0;
          end
        end

        S_RUN: begin
          // Saturate at the last settle count; the flag decides from there.
          if (!w_settled) begin
            r_settle <= r_settle + SW'(1);
          end
          if (w_settled && mm_flag) begin
            r_buf <= mm_out;
          end
        end

        S_NEXT: begin
          if (w_last_layer) begin
            r_scan <= '0;
          end else begin
            r_layer  <= r_layer + 2'd1;
            r_settle <= '0;
          end
        end

        S_ARGMAX: begin
          r_scan    <= r_scan + CW'(1);
          r_max_idx <= w_win_idx;
          if (w_take) begin
            r_max <= w_elem;
          end
          if (w_scan_last) begin
            r_out_vec   <= r_buf;
            r_out_class <= w_win_idx;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Bench for layer_sequencer. A stub mat_mul (full matrix multiply, Q11 shift,
// per-layer bias, optional ReLU, programmable per-layer flag delay) sits on
// the mat_mul side. A transaction-level model predicts, from the accept cycle
// and the stub configuration, which phase the controller must be in on every
// cycle and what the final vector and class must be; a compare process checks
// the DUT against it each cycle. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

  localparam int N      = 32;
  localparam int W      = 6;
  localparam int NL     = 4;
  localparam int SETTLE = 2;
  localparam int CW     = $clog2(W);

  typedef logic [W-1:0][N-1:0] vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  vec_t          in_vec;
  vec_t          mm_vec;
  logic [1:0]    mm_layer;
  logic          mm_done;
  logic          mm_flag;
  vec_t          mm_out;
  logic          out_valid;
  logic          out_ready;
  vec_t          out_vec;
  logic [CW-1:0] out_class;
  logic          busy;

  layer_sequencer #(
    .N(N), .W(W), .NUM_LAYERS(NL), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .mm_vec(mm_vec), .mm_layer(mm_layer), .mm_done(mm_done),
    .mm_flag(mm_flag), .mm_out(mm_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_class(out_class), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [W*N-1:0] act,
                       input logic [W*N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stub mat_mul
  // ---------------------------------------------------------------------------
  int wgt  [W][W];
  int bias [NL];
  int dly  [NL];
  bit relu_en;
  int win = 0;

  function automatic vec_t stub_mm(input vec_t x, input logic [1:0] l);
    vec_t   y;
    longint acc;
    for (int i = 0; i < W; i++) begin
      acc = 0;
      for (int j = 0; j < W; j++) begin
        acc += longint'(wgt[i][j]) * longint'($signed(x[j]));
      end
      acc = (acc >>> 11) + longint'(bias[l]);
      if (relu_en && acc < 0) acc = 0;
      y[i] = acc[N-1:0];
    end
    return y;
  endfunction

  always_comb mm_out = stub_mm(mm_vec, mm_layer);

  // Flag rises `dly` cycles into the compute window and clears on mm_done.
  always_ff @(posedge clk) begin
    if (mm_done) win <= 0;
    else         win <= win + 1;
  end

  always_comb mm_flag = !mm_done && (win >= dly[mm_layer]);

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  function automatic vec_t layer_fn(input vec_t x, input int l);
    vec_t   y;
    longint s;
    for (int i = 0; i < W; i++) begin
      s = longint'($signed(x[i])) + longint'(bias[l]);
      if (relu_en && s < 0) s = 0;
      y[i] = s[N-1:0];
    end
    return y;
  endfunction

  function automatic int argmax(input vec_t x);
    int best = 0;
    for (int i = 1; i < W; i++) begin
      if ($signed(x[i]) > $signed(x[best])) best = i;
    end
    return best;
  endfunction

  function automatic vec_t mk(input int a0, input int a1, input int a2,
                              input int a3, input int a4, input int a5);
    vec_t v;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3; v[4] = a4; v[5] = a5;
    return v;
  endfunction

  bit   chk_en = 0;
  bit   m_active = 0;
  int   m_t = 0;
  int   m_len [NL];
  vec_t m_act [NL+1];
  int   m_cls = 0;

  // Phase within an inference, t cycles after the accepting edge: each layer
  // spends max(delay, SETTLE-1)+1 cycles in RUN and one in NEXT, then W cycles
  // of argmax, then DONE until the handshake.
  initial begin : compare
    bit is_run, is_done;
    int cur_l, base;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        is_run = 0; is_done = 0; cur_l = 0; base = 0;
        if (m_active) begin
          for (int l = 0; l < NL; l++) begin
            if (m_t >= base && m_t < base + m_len[l] - 1) begin
              is_run = 1; cur_l = l;
            end
            base += m_len[l];
          end
          is_done = (m_t >= base + W);
        end
        check("in_ready", in_ready, !m_active && !rst);
        check("busy", busy, m_active);
        check("mm_done", mm_done, !is_run);
        check("out_valid", out_valid, is_done);
        if (is_run) begin
          check("mm_layer", mm_layer, cur_l);
          check("mm_vec", mm_vec, m_act[cur_l]);
        end
        if (is_done) begin
          check("out_vec", out_vec, m_act[NL]);
          check("out_class", out_class, m_cls);
        end
        if (rst) begin
          m_active = 0;
        end else if (m_active) begin
          if (is_done && out_ready) m_active = 0;
          else m_t++;
        end else if (in_valid) begin
          m_active = 1;
          m_t      = 0;
          m_act[0] = in_vec;
          for (int l = 0; l < NL; l++) begin
            m_act[l+1] = layer_fn(m_act[l], l);
            m_len[l]   = ((dly[l] > SETTLE - 1) ? dly[l] : SETTLE - 1) + 2;
          end
          m_cls = argmax(m_act[NL]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic accept(input vec_t v, output bit got, output int a_cyc);
    in_vec   = v;
    in_valid = 1'b1;
    got      = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    a_cyc    = cyc;
    in_valid = 1'b0;
    check("accept", got, 1);
  endtask

  task automatic run_one(input string tag, input vec_t v, input int hold,
                         input int exp_lat, input vec_t exp_vec, input int exp_cls);
    bit got;
    int a_cyc;
    @(posedge clk); #1;
    out_ready = (hold == 0);
    accept(v, got, a_cyc);
    if (got) begin
      got = 0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        got = out_valid;
      end
      check({tag, "_valid_seen"}, got, 1);
      if (got) begin
        check({tag, "_latency"}, cyc - a_cyc, exp_lat);
        check({tag, "_vec"}, out_vec, exp_vec);
        check({tag, "_class"}, out_class, exp_cls);
        for (int h = 1; h < hold; h++) begin
          @(posedge clk); #1;
          in_valid = h[0];
          in_vec   = ~v;
          @(negedge clk);
          check({tag, "_hold_valid"}, out_valid, 1);
          check({tag, "_hold_vec"}, out_vec, exp_vec);
          check({tag, "_hold_class"}, out_class, exp_cls);
          check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        if (hold > 0) begin
          @(posedge clk); #1;
          in_valid  = 1'b0;
          out_ready = 1'b1;
          @(negedge clk);
          check({tag, "_xfer_valid"}, out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_released"}, out_valid, 0);
        check({tag, "_idle"}, busy, 0);
      end
    end
  endtask

  initial begin : stimulus
    bit got;
    int a_cyc;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0; relu_en = 1;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        wgt[i][j] = (i == j) ? 2048 : 0;
    for (int l = 0; l < NL; l++) begin bias[l] = 0; dly[l] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_mm_done", mm_done, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_vec", out_vec, 0);
    check("rst_out_class", out_class, 0);
    check("rst_mm_vec", mm_vec, 0);
    check("rst_mm_layer", mm_layer, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    // Identity pass, ties resolve low, transfer in the first DONE cycle
    run_one("ident", mk(100, -50, 300, 7, 300, 0), 0, 18,
            mk(100, 0, 300, 7, 300, 0), 2);

    // Downstream stalls for 5 DONE cycles
    run_one("stall", mk(100, -50, 300, 7, 300, 0), 5, 18,
            mk(100, 0, 300, 7, 300, 0), 2);

    // Layer-1 flag late by 10 cycles
    dly[1] = 11;
    run_one("lateflag", mk(100, -50, 300, 7, 300, 0), 0, 28,
            mk(100, 0, 300, 7, 300, 0), 2);
    dly[1] = 0;

    // Reset during the layer-2 compute window
    @(posedge clk); #1;
    accept(mk(11, 22, 33, 44, 55, 66), got, a_cyc);
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = !mm_done && (mm_layer == 2'd2);
    end
    check("abort_reach_layer2", got, 1);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mm_done", mm_done, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_vec", out_vec, 0);
    check("abort_out_class", out_class, 0);
    check("abort_mm_vec", mm_vec, 0);
    check("abort_mm_layer", mm_layer, 0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 0);
    run_one("after_abort", mk(-8, 40, 12, 40, -1, 39), 0, 18,
            mk(0, 40, 12, 40, 0, 39), 1);

    // Back-to-back with in_valid and out_ready tied high
    begin : b2b
      vec_t bv [3];
      int   acc_c [3];
      int   nacc;
      int   cls_q [$];
      bit   rdy;
      bv[0] = mk(1, 2, 3, 4, 5, 6);
      bv[1] = mk(9, 8, 7, 6, 5, 4);
      bv[2] = mk(3, -1, 8, 8, 2, 8);
      @(posedge clk); #1;
      out_ready = 1'b1; in_vec = bv[0]; in_valid = 1'b1; nacc = 0;
      for (int k = 0; k < 150 && (nacc < 3 || cls_q.size() < 3); k++) begin
        @(negedge clk);
        if (out_valid) cls_q.push_back(int'(out_class));
        rdy = in_ready && in_valid;
        @(posedge clk); #1;
        if (rdy) begin
          acc_c[nacc] = cyc;
          nacc++;
          if (nacc < 3) in_vec = bv[nacc];
          else in_valid = 1'b0;
        end
      end
      out_ready = 1'b0;
      check("b2b_accepts", nacc, 3);
      check("b2b_results", cls_q.size(), 3);
      check("b2b_gap01", acc_c[1] - acc_c[0], 20);
      check("b2b_gap12", acc_c[2] - acc_c[1], 20);
      check("b2b_class0", cls_q[0], 5);
      check("b2b_class1", cls_q[1], 0);
      check("b2b_class2", cls_q[2], 2);
    end

    // All-negative input collapses to zeros, class 0
    run_one("allneg", mk(-1, -2, -3, -4, -5, -6), 0, 18, mk(0, 0, 0, 0, 0, 0), 0);

    // Per-layer bias and staggered flag delays (flag on time in layer 2)
    bias[0] = -20; bias[1] = 5; bias[2] = 0; bias[3] = 33;
    dly[0] = 3; dly[1] = 0; dly[2] = 1; dly[3] = 2;
    run_one("bias", mk(-5, 10, 40, -100, 0, 25), 0, 21,
            mk(38, 38, 58, 38, 38, 43), 2);
    for (int l = 0; l < NL; l++) begin bias[l] = 0; dly[l] = 0; end

    // Linear mat_mul: negative values reach the argmax (signed compare)
    relu_en = 0;
    run_one("signed", mk(-7, 5, -3, 5, -100, 2), 0, 18,
            mk(-7, 5, -3, 5, -100, 2), 1);
    relu_en = 1;

    @(posedge clk); #1;
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "simulation time limit reached");
  end

endmodule
